// File: rtl/fetch_sequencer.sv
// Two-byte instruction fetch sequencer: pulls a little-endian 16-bit word from a
// byte-wide memory, stepping the PC once per accepted byte, with a per-byte timeout.
module fetch_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [15:0] Address,
    input  logic        MemReady,
    input  logic [7:0]  MemData,
    output logic        MemRead,
    output logic [15:0] MemAddr,
    output logic [2:0]  ARF_FunSel,
    output logic [2:0]  ARF_RegSel,
    output logic [15:0] IROut,
    output logic        IRValid,
    output logic        Busy,
    output logic        Error
);
    localparam logic [3:0] TMO = 4'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, LSB, MSB, DONE} state_t;

    state_t      state_q;
    logic [3:0]  wait_q;
    logic [15:0] ir_q;
    logic        valid_q;
    logic        err_q;
    logic        fetching;
    logic        accept;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            wait_q  <= '0;
            ir_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: if (Start) begin
                    state_q <= LSB;
                    err_q   <= 1'b0;
                    wait_q  <= '0;
                end
                LSB, MSB: begin
                    // A byte arriving on the last allowed wait cycle still wins over the timeout.
                    if (MemReady) begin
                        wait_q <= '0;
                        if (state_q == LSB) begin
                            ir_q[7:0] <= MemData;
                            state_q   <= MSB;
                        end else begin
                            ir_q[15:8] <= MemData;
                            state_q    <= DONE;
                            valid_q    <= 1'b1;
                        end
                    end else if (wait_q == TMO) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        wait_q <= wait_q + 4'd1;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Reset masks the bus and PC strobes so an interrupted fetch cannot bump the PC.
    assign fetching   = (state_q == LSB || state_q == MSB) && !Reset;
    assign accept     = fetching && MemReady;
    assign MemRead    = fetching;
    assign MemAddr    = fetching ? Address : 16'h0000;
    assign ARF_RegSel = accept ? 3'b011 : 3'b111;
    assign ARF_FunSel = accept ? 3'b001 : 3'b000;
    assign Busy       = (state_q != IDLE) && !Reset;
    assign IROut      = ir_q;
    assign IRValid    = valid_q;
    assign Error      = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: PC model counts increment strobes, expected words
// are queued at Start and popped on IRValid.
module tb_fetch_sequencer;
    logic        Clock = 1'b0;
    logic        Reset, Start, MemReady;
    logic [7:0]  MemData;
    logic [15:0] Address, MemAddr, IROut;
    logic        MemRead, IRValid, Busy, Error;
    logic [2:0]  ARF_FunSel, ARF_RegSel;

    int          tests = 0;
    int          fails = 0;
    int          inc_total = 0;
    logic [15:0] base = 16'h0000;
    logic [15:0] sb[$];

    fetch_sequencer #(.TIMEOUT(15)) dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Address(Address),
        .MemReady(MemReady), .MemData(MemData), .MemRead(MemRead), .MemAddr(MemAddr),
        .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel), .IROut(IROut),
        .IRValid(IRValid), .Busy(Busy), .Error(Error)
    );

    always #5 Clock = ~Clock;

    // Address register file model: PC increments only on the exact PC+INC strobe.
    always @(posedge Clock)
        if (!Reset && ARF_RegSel == 3'b011 && ARF_FunSel == 3'b001)
            inc_total <= inc_total + 1;
    assign Address = base + inc_total[15:0];

    task automatic test_reset();
        Reset = 1'b1; Start = 1'b0; MemReady = 1'b1; MemData = 8'hFF;
        repeat (2) @(negedge Clock);
        #1;
        tests++;
        if (MemRead !== 1'b0 || Busy !== 1'b0 || ARF_RegSel !== 3'b111 || ARF_FunSel !== 3'b000 ||
            IROut !== 16'h0000 || IRValid !== 1'b0 || Error !== 1'b0) begin
            fails++;
            $display("FAIL reset_hold: rd=%b busy=%b sel=%b fun=%b ir=%h v=%b err=%b, need 0 0 111 000 0000 0 0",
                     MemRead, Busy, ARF_RegSel, ARF_FunSel, IROut, IRValid, Error);
        end
        @(negedge Clock); Reset = 1'b0; #1;
        tests++;
        if (Busy !== 1'b0 || MemRead !== 1'b0 || MemAddr !== 16'h0000 || ARF_RegSel !== 3'b111 || inc_total != 0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b rd=%b addr=%h sel=%b incs=%0d, need 0 0 0000 111 0",
                     Busy, MemRead, MemAddr, ARF_RegSel, inc_total);
        end
        @(negedge Clock); MemReady = 1'b0;
    endtask

    // One fetch with d0/d1 wait cycles before each byte is presented.
    task automatic do_fetch(input string nm, input logic [15:0] addr, input logic [7:0] b0,
                            input logic [7:0] b1, input int d0, input int d1);
        int inc0;
        logic [15:0] exp;
        logic rdy;
        base = addr - 16'(inc_total);
        inc0 = inc_total;
        sb.push_back({b1, b0});
        @(negedge Clock); Start = 1'b1; MemReady = 1'b0; #1;
        tests++;
        if (Busy !== 1'b0) begin
            fails++; $display("FAIL %s_idle: busy=%b need 0", nm, Busy);
        end
        for (int ph = 0; ph < 2; ph++) begin
            int d;
            d = (ph == 0) ? d0 : d1;
            for (int i = 0; i <= d; i++) begin
                @(negedge Clock);
                Start = 1'b0; rdy = (i == d); MemReady = rdy; MemData = (ph == 0) ? b0 : b1;
                #1;
                tests++;
                if (MemRead !== 1'b1 || MemAddr !== addr + 16'(ph) || Busy !== 1'b1 || Error !== 1'b0 ||
                    IRValid !== 1'b0 || ARF_RegSel !== (rdy ? 3'b011 : 3'b111) ||
                    ARF_FunSel !== (rdy ? 3'b001 : 3'b000) || (ph == 1 && IROut[7:0] !== b0)) begin
                    fails++;
                    $display("FAIL %s_byte%0d_cyc%0d: rd=%b addr=%h busy=%b err=%b v=%b sel=%b fun=%b ir=%h, need addr=%h rdy=%b",
                             nm, ph, i, MemRead, MemAddr, Busy, Error, IRValid, ARF_RegSel, ARF_FunSel,
                             IROut, addr + 16'(ph), rdy);
                end
            end
        end
        @(negedge Clock); MemReady = 1'b0; #1;
        exp = 16'hxxxx;
        tests++;
        if (IRValid !== 1'b1 || sb.size() == 0) begin
            fails++; $display("FAIL %s_valid: IRValid=%b queue=%0d, need 1", nm, IRValid, sb.size());
        end else begin
            exp = sb.pop_front();
            if (IROut !== exp) begin
                fails++; $display("FAIL %s_word: IROut=%h need %h", nm, IROut, exp);
            end
        end
        tests++;
        if (inc_total - inc0 != 2 || Error !== 1'b0) begin
            fails++; $display("FAIL %s_pcinc: incs=%0d err=%b, need 2 0", nm, inc_total - inc0, Error);
        end
        @(negedge Clock); #1;
        tests++;
        if (IRValid !== 1'b0 || Busy !== 1'b0 || IROut !== exp) begin
            fails++; $display("FAIL %s_after: v=%b busy=%b ir=%h, need 0 0 %h", nm, IRValid, Busy, IROut, exp);
        end
    endtask

    task automatic test_basic();
        do_fetch("basic", 16'h0040, 8'h34, 8'h12, 0, 0);
    endtask

    task automatic test_wait_states();
        do_fetch("wait", 16'h0100, 8'hEF, 8'hBE, 5, 2);
    endtask

    task automatic test_timeout();
        int inc0;
        base = 16'h1000 - 16'(inc_total);
        inc0 = inc_total;
        @(negedge Clock); Start = 1'b1; MemReady = 1'b0;
        @(negedge Clock); Start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            #1;
            tests++;
            if (Busy !== 1'b1 || Error !== 1'b0 || MemRead !== 1'b1 || MemAddr !== 16'h1000 || IRValid !== 1'b0) begin
                fails++;
                $display("FAIL timeout_wait%0d: busy=%b err=%b rd=%b addr=%h v=%b, need 1 0 1 1000 0",
                         i, Busy, Error, MemRead, MemAddr, IRValid);
            end
            @(negedge Clock);
        end
        #1;
        tests++;
        if (Busy !== 1'b0 || Error !== 1'b1 || IRValid !== 1'b0 || inc_total != inc0 || MemRead !== 1'b0) begin
            fails++;
            $display("FAIL timeout_abort: busy=%b err=%b v=%b incs=%0d rd=%b, need 0 1 0 0 0",
                     Busy, Error, IRValid, inc_total - inc0, MemRead);
        end
        @(negedge Clock); #1;
        tests++;
        if (Error !== 1'b1 || Busy !== 1'b0) begin
            fails++; $display("FAIL timeout_sticky: err=%b busy=%b, need 1 0", Error, Busy);
        end
        do_fetch("after_to", 16'h1000, 8'h5A, 8'hC3, 1, 0);
    endtask

    task automatic test_boundary();
        do_fetch("boundary", 16'h2000, 8'hCD, 8'hAB, 15, 15);
    endtask

    task automatic test_reset_mid();
        int inc0;
        base = 16'h2800 - 16'(inc_total);
        inc0 = inc_total;
        @(negedge Clock); Start = 1'b1; MemReady = 1'b0;
        @(negedge Clock); Start = 1'b0; MemReady = 1'b1; MemData = 8'h77;
        @(negedge Clock); Reset = 1'b1; MemReady = 1'b1; MemData = 8'h88; #1;
        tests++;
        if (MemRead !== 1'b0 || ARF_RegSel !== 3'b111 || ARF_FunSel !== 3'b000 || Busy !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_mask: rd=%b sel=%b fun=%b busy=%b, need 0 111 000 0",
                     MemRead, ARF_RegSel, ARF_FunSel, Busy);
        end
        @(negedge Clock); Reset = 1'b0; MemReady = 1'b1; MemData = 8'h99; #1;
        tests++;
        if (Busy !== 1'b0 || IROut !== 16'h0000 || IRValid !== 1'b0 || inc_total - inc0 != 1 ||
            ARF_RegSel !== 3'b111 || MemRead !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_idle: busy=%b ir=%h v=%b incs=%0d sel=%b rd=%b, need 0 0000 0 1 111 0",
                     Busy, IROut, IRValid, inc_total - inc0, ARF_RegSel, MemRead);
        end
        @(negedge Clock); MemReady = 1'b0; #1;
        tests++;
        if (Busy !== 1'b0 || IROut !== 16'h0000 || inc_total - inc0 != 1) begin
            fails++;
            $display("FAIL rstmid_noresume: busy=%b ir=%h incs=%0d, need 0 0000 1", Busy, IROut, inc_total - inc0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bt [4];
        int inc0, ph, f;
        logic [15:0] exp;
        bt[0] = 8'h11; bt[1] = 8'h22; bt[2] = 8'h33; bt[3] = 8'h44;
        base = 16'h3000 - 16'(inc_total);
        inc0 = inc_total;
        sb.push_back(16'h2211);
        sb.push_back(16'h4433);
        for (int k = 0; k < 8; k++) begin
            ph = k % 4; f = k / 4;
            @(negedge Clock);
            Start = 1'b1; MemReady = 1'b1; MemData = (ph == 1) ? bt[2*f] : bt[2*f+1];
            #1;
            tests++;
            if (Busy !== (ph != 0) || IRValid !== (ph == 3) ||
                ARF_RegSel !== ((ph == 1 || ph == 2) ? 3'b011 : 3'b111) ||
                ((ph == 1 || ph == 2) && MemAddr !== 16'h3000 + 16'(2*f + ph - 1))) begin
                fails++;
                $display("FAIL b2b_cyc%0d: busy=%b v=%b sel=%b addr=%h", k, Busy, IRValid, ARF_RegSel, MemAddr);
            end
            if (ph == 3) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++; $display("FAIL b2b_word%0d: queue empty, IROut=%h", f, IROut);
                end else begin
                    exp = sb.pop_front();
                    if (IROut !== exp) begin
                        fails++; $display("FAIL b2b_word%0d: IROut=%h need %h", f, IROut, exp);
                    end
                end
            end
        end
        @(negedge Clock); Start = 1'b0; MemReady = 1'b0; #1;
        tests++;
        if (Busy !== 1'b0 || inc_total - inc0 != 4) begin
            fails++; $display("FAIL b2b_end: busy=%b incs=%0d, need 0 4", Busy, inc_total - inc0);
        end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; MemReady = 1'b0; MemData = 8'h00;
        test_reset();
        test_basic();
        test_wait_states();
        test_timeout();
        test_boundary();
        test_reset_mid();
        test_back_to_back();
        tests++;
        if (sb.size() != 0) begin
            fails++; $display("FAIL scoreboard_drain: %0d words left, need 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
